// File: rtl/interrupt_controller_pkg.sv
// Shared bus-peripheral definitions for the interrupt controller:
// register offsets, FSM encoding and the VECTOR/CONTROL bit positions.
package interrupt_controller_pkg;

  localparam int NUM_SRC = 8;

  localparam logic [1:0] REG_PENDING = 2'd0;
  localparam logic [1:0] REG_MASK    = 2'd1;
  localparam logic [1:0] REG_VECTOR  = 2'd2;  // any write here is end-of-interrupt
  localparam logic [1:0] REG_CONTROL = 2'd3;

  localparam int VEC_VALID_BIT = 7;
  localparam int CTRL_MODE_BIT = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RAISE   = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

  function automatic logic [NUM_SRC-1:0] idx_to_onehot(input logic [2:0] idx);
    return NUM_SRC'(1) << idx;
  endfunction

endpackage

// File: rtl/interrupt_controller_arbiter.sv
// Combinational arbiter: first eligible source found when searching upward
// from 'start' (round-robin) or from 0 (fixed priority), wrapping 7->0.
module irq_arbiter
  import interrupt_controller_pkg::*;
(
  input  logic [NUM_SRC-1:0] eligible,
  input  logic [2:0]         start,
  input  logic               mode,
  output logic               grant_valid,
  output logic [2:0]         grant_idx
);

  logic [2:0] base;
  logic [2:0] idx;

  // Scan from the farthest offset down so the nearest eligible source wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 3'd0;
    base        = mode ? start : 3'd0;
    idx         = 3'd0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = base + 3'(k);
      if (eligible[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Eight-source interrupt controller with a 4-byte memory-mapped register
// window, edge-latched pending bits and a RAISE/ACK/EOI handshake.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR  = 8'hE8,
  parameter logic       RR_DEFAULT = 1'b0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] BUS_ADDR,
  inout  wire  [7:0] BUS_DATA,
  input  logic       BUS_WE,
  input  logic [7:0] SRC_IRQ,
  output logic [7:0] SRC_ACK,
  output logic       IRQ_RAISE,
  input  logic       IRQ_ACK
);

  irq_state_e state, state_nxt;

  logic [7:0] pending, mask, irq_prev, rise, clr;
  logic       mode;
  logic [2:0] cur, last, vec_idx;
  logic       vec_valid;
  logic [7:0] offset, vector, rd_mux;
  logic       hit, wr, rd, grant, eoi;
  logic       arb_valid;
  logic [2:0] arb_idx;
  logic [7:0] rd_data_p1;
  logic       rd_vld_p1;

  assign offset = BUS_ADDR - BASE_ADDR;
  assign hit    = (offset < 8'd4);
  assign wr     = hit & BUS_WE;
  assign rd     = hit & ~BUS_WE;
  assign eoi    = wr && (offset[1:0] == REG_VECTOR);
  assign grant  = (state == ST_RAISE) && IRQ_ACK;
  assign rise   = SRC_IRQ & ~irq_prev;

  // A new edge is OR-ed in after the clear, so it always survives.
  assign clr = ((wr && offset[1:0] == REG_PENDING) ? BUS_DATA : 8'h00)
             | (grant ? idx_to_onehot(cur) : 8'h00);

  irq_arbiter u_arb (
    .eligible    (pending & mask),
    .start       (last + 3'd1),
    .mode        (mode),
    .grant_valid (arb_valid),
    .grant_idx   (arb_idx)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (arb_valid) state_nxt = ST_RAISE;
      ST_RAISE:   if (IRQ_ACK)   state_nxt = ST_SERVICE;
      ST_SERVICE: if (eoi)       state_nxt = ST_IDLE;
      default:                   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    IRQ_RAISE = (state == ST_RAISE);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      irq_prev  <= 8'h00;
      pending   <= 8'h00;
      mask      <= 8'h00;
      mode      <= RR_DEFAULT;
      cur       <= 3'd0;
      last      <= 3'd7;
      vec_valid <= 1'b0;
      vec_idx   <= 3'd0;
      SRC_ACK   <= 8'h00;
    end else begin
      irq_prev <= SRC_IRQ;
      pending  <= (pending & ~clr) | rise;
      if (wr && offset[1:0] == REG_MASK)    mask <= BUS_DATA;
      if (wr && offset[1:0] == REG_CONTROL) mode <= BUS_DATA[CTRL_MODE_BIT];
      // CUR is only latched from IDLE, so it is frozen through RAISE.
      if (state == ST_IDLE && arb_valid) cur <= arb_idx;
      SRC_ACK <= grant ? idx_to_onehot(cur) : 8'h00;
      if (grant) begin
        last      <= cur;
        vec_valid <= 1'b1;
        vec_idx   <= cur;
      end else if (eoi && state == ST_SERVICE) begin
        vec_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    vector                = 8'h00;
    vector[VEC_VALID_BIT] = vec_valid;
    vector[2:0]           = vec_idx;
    case (offset[1:0])
      REG_PENDING: rd_mux = pending;
      REG_MASK:    rd_mux = mask;
      REG_VECTOR:  rd_mux = vector;
      default:     rd_mux = {7'b0, mode};
    endcase
  end

  // Read stage: data is registered and put on the bus one cycle later.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rd_vld_p1  <= 1'b0;
      rd_data_p1 <= 8'h00;
    end else begin
      rd_vld_p1  <= rd;
      rd_data_p1 <= rd_mux;
    end
  end

  assign BUS_DATA = rd_vld_p1 ? rd_data_p1 : 8'hzz;

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench for interrupt_controller: stimulus pushes expected SRC_ACK
// pulses and read data, a negedge monitor pops and compares them.
module tb_interrupt_controller;

  localparam logic [7:0] BASE = 8'hE8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] bus_addr;
  wire  [7:0] bus_data;
  logic       bus_we;
  logic [7:0] src_irq;
  logic [7:0] src_ack;
  logic       irq_raise;
  logic       irq_ack;
  logic [7:0] tb_data;
  logic       tb_drv;

  assign bus_data = tb_drv ? tb_data : 8'hzz;

  always #5 clk = ~clk;

  interrupt_controller dut (
    .CLK       (clk),
    .RESET     (rst_n),
    .BUS_ADDR  (bus_addr),
    .BUS_DATA  (bus_data),
    .BUS_WE    (bus_we),
    .SRC_IRQ   (src_irq),
    .SRC_ACK   (src_ack),
    .IRQ_RAISE (irq_raise),
    .IRQ_ACK   (irq_ack)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] ack_q[$];
  logic [7:0] rd_q[$];
  string      rd_name_q[$];
  logic       rd_phase = 1'b0;

  // Reference model state
  logic [7:0] m_pend, m_mask, m_vec;
  logic       m_mode;
  int         m_last;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (src_ack !== 8'h00) begin
      if (ack_q.size() == 0) check8("src_ack_unexpected", src_ack, 8'h00);
      else check8("src_ack", src_ack, ack_q.pop_front());
    end
    if (rd_phase) begin
      if (rd_q.size() == 0) check8("read_unexpected", bus_data, 8'h00);
      else check8(rd_name_q.pop_front(), bus_data, rd_q.pop_front());
    end
  end

  task automatic model_reset();
    m_pend = 8'h00; m_mask = 8'h00; m_vec = 8'h00; m_mode = 1'b0; m_last = 7;
  endtask

  function automatic int model_pick();
    int s;
    int i;
    s = m_mode ? (m_last + 1) % 8 : 0;
    for (int k = 0; k < 8; k++) begin
      i = (s + k) % 8;
      if (m_pend[i] && m_mask[i]) return i;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] off, input logic [7:0] d, input logic [7:0] src);
    bus_addr = BASE + 8'(off);
    bus_we = 1'b1; tb_drv = 1'b1; tb_data = d; src_irq = src;
    tick();
    bus_we = 1'b0; tb_drv = 1'b0; bus_addr = 8'h00; src_irq = 8'h00;
    case (off)
      2'd0: m_pend = m_pend & ~d;
      2'd1: m_mask = d;
      2'd2: if (m_vec[7] && !irq_raise) m_vec = m_vec; // EOI outside SERVICE is handled by callers
      default: m_mode = d[0];
    endcase
    m_pend = m_pend | src;
  endtask

  task automatic bus_read(input logic [1:0] off, input logic [7:0] exp, input string name);
    bus_addr = BASE + 8'(off);
    bus_we = 1'b0;
    tick();
    bus_addr = 8'h00;
    rd_q.push_back(exp);
    rd_name_q.push_back(name);
    rd_phase = 1'b1;
    tick();
    rd_phase = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] bits);
    src_irq = bits;
    tick();
    src_irq = 8'h00;
    m_pend = m_pend | bits;
  endtask

  task automatic wait_raise(input int bound, output bit ok);
    ok = 1'b0;
    for (int k = 0; k <= bound; k++) begin
      if (irq_raise) begin
        ok = 1'b1;
        break;
      end
      if (k < bound) tick();
    end
    check8("irq_raise_timeout", {7'b0, irq_raise}, 8'h01);
  endtask

  task automatic raise_and_ack(input int bound, input bit eoi_first, input logic [7:0] src_at_ack,
                               output int idx);
    bit         ok;
    logic [7:0] oh;
    idx = -1;
    wait_raise(bound, ok);
    if (!ok) return;
    if (eoi_first) begin
      bus_write(2'd2, 8'h5A, 8'h00);
      check8("eoi_in_raise_ignored", {7'b0, irq_raise}, 8'h01);
    end
    idx = model_pick();
    if (idx < 0) begin
      check8("raise_without_eligible", {7'b0, irq_raise}, 8'h00);
      return;
    end
    oh = 8'h01 << idx;
    ack_q.push_back(oh);
    irq_ack = 1'b1; src_irq = src_at_ack;
    tick();
    irq_ack = 1'b0; src_irq = 8'h00;
    m_pend = (m_pend & ~oh) | src_at_ack;
    m_last = idx;
    m_vec  = 8'h80 | 8'(idx);
    check8("irq_raise_low_in_service", {7'b0, irq_raise}, 8'h00);
  endtask

  task automatic finish_service(input logic [7:0] repulse);
    bus_read(2'd2, m_vec, "vector_in_service");
    if (repulse != 8'h00) pulse(repulse);
    bus_write(2'd2, 8'h00, 8'h00);
    m_vec = m_vec & 8'h07;
  endtask

  task automatic drain(input bit repulse_en);
    int         idx;
    int         g;
    logic [7:0] rp;
    g = 0;
    while ((m_pend & m_mask) != 8'h00 && g < 20) begin
      raise_and_ack(4, 1'b0, 8'h00, idx);
      if (idx < 0) break;
      rp = (repulse_en && g < 6 && $urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      finish_service(rp);
      g++;
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    #1;
    check8("reset_drops_raise", {7'b0, irq_raise}, 8'h00);
    model_reset();
    tick();
    check8("reset_src_ack", src_ack, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         idx;
    logic [7:0] d;
    rst_n = 1'b0; bus_addr = 8'h00; bus_we = 1'b0; src_irq = 8'h00;
    irq_ack = 1'b0; tb_data = 8'h00; tb_drv = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Reset state
    check8("reset_irq_raise", {7'b0, irq_raise}, 8'h00);
    check8("reset_src_ack", src_ack, 8'h00);
    bus_read(2'd0, 8'h00, "reset_pending");
    bus_read(2'd1, 8'h00, "reset_mask");
    bus_read(2'd2, 8'h00, "reset_vector");
    bus_read(2'd3, 8'h00, "reset_control");

    // Single source, masked window 0F, EOI during RAISE ignored
    bus_write(2'd1, 8'h0F, 8'h00);
    pulse(8'h04);
    bus_read(2'd0, 8'h04, "pending_src2");
    raise_and_ack(4, 1'b1, 8'h00, idx);
    finish_service(8'h00);
    bus_read(2'd0, 8'h00, "pending_after_grant");

    // Fixed priority: sources 1 and 5 together
    bus_write(2'd1, 8'hFF, 8'h00);
    pulse(8'h22);
    drain(1'b0);

    // Round-robin from reset LAST=7 with 0,3,6 re-asserted
    reset_dut();
    bus_write(2'd1, 8'hFF, 8'h00);
    bus_write(2'd3, 8'h01, 8'h00);
    bus_read(2'd3, 8'h01, "control_rr");
    pulse(8'h49);
    for (int k = 0; k < 4; k++) begin
      raise_and_ack(4, 1'b0, 8'h00, idx);
      if (idx < 0) break;
      finish_service(k < 3 ? (8'h01 << idx) : 8'h00);
    end
    drain(1'b0);

    // Masked source latches but does not raise
    bus_write(2'd1, 8'h00, 8'h00);
    pulse(8'h10);
    repeat (3) tick();
    check8("masked_no_raise", {7'b0, irq_raise}, 8'h00);
    bus_read(2'd0, 8'h10, "masked_pending");
    bus_write(2'd1, 8'h10, 8'h00);
    raise_and_ack(2, 1'b0, 8'h00, idx);
    finish_service(8'h00);

    // Set overrides W1C clear
    bus_write(2'd1, 8'h00, 8'h00);
    bus_write(2'd0, 8'h10, 8'h10);
    bus_read(2'd0, 8'h10, "w1c_vs_edge");
    bus_write(2'd0, 8'h10, 8'h00);
    bus_read(2'd0, 8'h00, "w1c_clear");

    // Set overrides grant clear
    bus_write(2'd1, 8'h10, 8'h00);
    pulse(8'h10);
    raise_and_ack(4, 1'b0, 8'h10, idx);
    bus_read(2'd0, m_pend, "grant_vs_edge");
    finish_service(8'h00);
    drain(1'b0);

    // Reset mid-RAISE
    pulse(8'h10);
    begin
      bit ok;
      wait_raise(4, ok);
    end
    reset_dut();
    bus_read(2'd0, 8'h00, "pending_after_reset_raise");
    bus_read(2'd2, 8'h00, "vector_after_reset_raise");

    // Reset mid-SERVICE
    bus_write(2'd1, 8'h10, 8'h00);
    pulse(8'h10);
    raise_and_ack(4, 1'b0, 8'h00, idx);
    tick();
    reset_dut();
    check8("raise_after_reset_service", {7'b0, irq_raise}, 8'h00);
    bus_read(2'd2, 8'h00, "vector_after_reset_service");
    bus_read(2'd1, 8'h00, "mask_after_reset_service");
    bus_read(2'd0, 8'h00, "pending_after_reset_service");

    // Randomized traffic against the model
    for (int it = 0; it < 40; it++) begin
      bus_write(2'd3, 8'($urandom), 8'h00);
      if ($urandom_range(0, 3) == 0) begin
        bus_write(2'd2, 8'($urandom), 8'h00);
        bus_read(2'd2, m_vec, "vector_eoi_idle");
      end
      if ($urandom_range(0, 3) == 0) bus_write(2'd0, 8'($urandom), 8'h00);
      d = 8'($urandom);
      bus_write(2'd1, d, 8'($urandom));
      if ((m_pend & m_mask) == 8'h00) begin
        repeat (2) tick();
        check8("rand_no_raise", {7'b0, irq_raise}, 8'h00);
      end else begin
        drain(1'b1);
      end
      bus_read(2'd0, m_pend, "rand_pending");
      bus_read(2'd3, {7'b0, m_mode}, "rand_control");
    end

    repeat (3) tick();
    check8("ack_queue_drained", 8'(ack_q.size()), 8'h00);
    check8("read_queue_drained", 8'(rd_q.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter BASE_ADDR, default 8'hE8: base of the 4-byte register window on the shared bus.
REQ-002 Parameter RR_DEFAULT, default 1'b0: CONTROL.mode value at reset (0 = fixed priority, 1 = round-robin).
REQ-003 CLK  input  1  system clock; all state SHALL update on the rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset.
REQ-005 BUS_ADDR  input  8  shared bus address.
REQ-006 BUS_DATA  inout  8  shared bus data; driven only during a read of this block, high-Z otherwise.
REQ-007 BUS_WE  input  1  bus write enable.
REQ-008 SRC_IRQ  input  8  peripheral interrupt requests; bit 0 is highest fixed priority.
REQ-009 SRC_ACK  output  8  one-cycle acknowledge pulse per source.
REQ-010 IRQ_RAISE  output  1  interrupt request to the processor.
REQ-011 IRQ_ACK  input  1  processor acknowledge.

Function
REQ-012 Register map SHALL be:
- BASE+0 PENDING: read; write-1-to-clear.
- BASE+1 MASK: R/W; 1 = enabled.
- BASE+2 VECTOR: read {valid, 4'b0, idx[2:0]}; any write = end-of-interrupt (EOI).
- BASE+3 CONTROL: R/W; bit0 = mode, other bits read 0.
REQ-013 Writes SHALL take effect at the clock edge where BUS_WE=1 and BUS_ADDR is in the window.
REQ-014 Read data SHALL be registered: BUS_DATA is driven in the cycle after BUS_ADDR hits the window with BUS_WE=0, and is high-Z in every other cycle.
REQ-015 PENDING[i] SHALL set on a rising edge of SRC_IRQ[i], detected by a registered previous value, so latency is 1 cycle.
REQ-016 A set event SHALL override a clear in the same cycle, whether the clear comes from W1C or from a grant.
REQ-017 Masked sources SHALL still latch PENDING but SHALL NOT be eligible for arbitration.
REQ-018 The FSM SHALL have three states:
- IDLE: if any (PENDING & MASK) bit is set, latch the winner into CUR and go to RAISE on the next edge.
- RAISE: IRQ_RAISE=1; on IRQ_ACK=1 go to SERVICE, pulse SRC_ACK[CUR] for exactly one cycle, clear PENDING[CUR], set VECTOR.valid=1 and VECTOR.idx=CUR.
- SERVICE: IRQ_RAISE=0; stay until an EOI write, then clear VECTOR.valid and go to IDLE.
REQ-019 Fixed mode: the winner SHALL be the lowest eligible index.
REQ-020 Round-robin mode: search SHALL start at (LAST+1) mod 8, where LAST is the index of the last granted source (reset value 7), wrapping 7->0.
REQ-021 CUR SHALL NOT change while in RAISE, even if the MASK bit for CUR is cleared.
REQ-022 An EOI written in IDLE or RAISE SHALL be ignored.
REQ-023 A mode change SHALL affect only arbitrations made after the write.
REQ-024 If PENDING[CUR] is set again while in SERVICE, it SHALL remain pending and be arbitrated after EOI.

Reset
REQ-025 While RESET=0, the block SHALL hold these values:
- FSM = IDLE; PENDING, previous-IRQ register and CUR = 0.
- MASK = 8'h00; CONTROL.mode = RR_DEFAULT; LAST = 7.
- VECTOR = 8'h00; SRC_ACK = 0; IRQ_RAISE = 0; BUS_DATA = high-Z.
REQ-026 Reset asserted mid-RAISE or mid-SERVICE SHALL drop IRQ_RAISE immediately, with no SRC_ACK pulse.
REQ-027 Source edges that occur while RESET=0 SHALL be lost.

Structure
REQ-028 Register offsets, FSM state encodings and the EOI/valid bit positions SHALL live in the shared bus-peripheral package.
REQ-029 Arbitration SHALL be a single sub-module, irq_arbiter, taking (eligible[7:0], start[2:0], mode) and returning (grant_valid, grant_idx[2:0]); it SHALL be purely combinational.
REQ-030 The bus read/write decode SHALL follow the same tri-state pattern as the existing memory-mapped peripherals.

Verification
REQ-031 Scenario: MASK=8'h0F, pulse SRC_IRQ[2] -> PENDING=8'h04 one cycle later; IRQ_RAISE next cycle; on IRQ_ACK, SRC_ACK=8'h04 for one cycle; VECTOR reads 8'h82.
REQ-032 Scenario: fixed mode, MASK=8'hFF, edges on sources 5 and 1 in the same cycle -> source 1 granted first; after EOI, source 5 granted; VECTOR reads 8'h81 then 8'h85.
REQ-033 Scenario: round-robin mode, sources 0, 3 and 6 held pending (re-asserted after each grant) -> grant order 0, 3, 6, 0 across four EOI cycles.
REQ-034 Scenario: MASK=8'h00, edge on source 4 -> PENDING=8'h10, IRQ_RAISE stays 0; then write MASK=8'h10 -> IRQ_RAISE within 2 cycles.
REQ-035 Scenario: W1C of 8'h10 in the same cycle as a new edge on source 4 -> PENDING bit 4 stays 1.
REQ-036 Scenario: assert RESET during SERVICE -> IRQ_RAISE=0, VECTOR=8'h00, MASK=8'h00; no SRC_ACK pulse; a BUS_DATA read after reset returns 8'h00.
